// File: rtl/mul_hilo_ctrl.sv
// Sequencing controller for a combinational 32x32 signed multiplier: latches the
// operands, waits SETTLE_CYCLES for the product to settle, then captures it into HI/LO.
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] mp_in,
    input  logic [31:0] mc_in,
    output logic [31:0] mp_out,
    output logic [31:0] mc_out,
    input  logic [31:0] prod_hi,
    input  logic [31:0] prod_lo,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    // WAIT counts down from SETTLE_CYCLES-1 to 0, so it lasts SETTLE_CYCLES cycles.
    localparam logic [7:0] CNT_INIT = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam bit         NO_WAIT  = (SETTLE_CYCLES == 0);

    state_t     state_q;
    logic [7:0] cnt_q;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, which is what makes this one block a
    // correct FSM with registered outputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mp_out  <= '0;
            mc_out  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;

            // Direct loads are applied in every state; the CAPTURE branch below
            // assigns HI/LO again, and the later assignment wins the collision.
            if (hi_we) hi_q <= hi_in;
            if (lo_we) lo_q <= lo_in;

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mp_out <= mp_in;
                        mc_out <= mc_in;
                        busy   <= 1'b1;
                        if (NO_WAIT) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt_q == 8'd0) state_q <= S_CAPTURE;
                    else               cnt_q   <= cnt_q - 8'd1;
                end

                S_CAPTURE: begin
                    hi_q    <= prod_hi;
                    lo_q    <= prod_lo;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
